// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   REG_ADDR_W  : register-file index width
//   sb_entry_t  : one in-flight destination record {valid, dest}
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/mips_scoreboard_shift.sv
// Shift-register scoreboard of in-flight destination registers.
// Slot 0 corresponds to EX, slot PIPE_DEPTH-1 to WB; the oldest entry falls off.
//   clk      : pipeline clock
//   reset    : synchronous, active-high; clears every slot
//   shift_en : advance all slots by one and load push into slot 0
//   push     : entry entering EX this cycle
//   entries  : parallel read-out of all slots
import mips_pkg::*;

module mips_scoreboard_shift #(
    parameter int PIPE_DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift_en,
    input  sb_entry_t                   push,
    output sb_entry_t [PIPE_DEPTH-1:0]  entries
);

    sb_entry_t [PIPE_DEPTH-1:0] slots;

    always_ff @(posedge clk) begin
        if (reset) begin
            slots <= '0;
        end else if (shift_en) begin
            slots[0] <= push;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    assign entries = slots;

endmodule

// File: rtl/mips_hazard_scheduler.sv
// Interlock controller for a 5-stage MIPS pipeline without forwarding.
// Compares the ID-stage sources against the in-flight destinations and
// stalls PC/IF-ID while injecting EX bubbles until the producer commits.
// Also handles branch flush and a global memory freeze.
//   clk, reset                 : clock, synchronous active-high reset
//   id_valid/rs/rt/uses_rs/rt  : ID-stage instruction sources
//   id_writes, id_dest         : ID-stage destination (already muxed)
//   flush                      : kill the instruction in ID
//   freeze                     : whole pipeline holds
//   pc_hold, ifid_hold         : front-end hold controls
//   idex_bubble                : ID/EX loads a NOP
//   issue                      : ID instruction moves to EX this cycle
//   stall_count                : saturating count of hazard-stall cycles
import mips_pkg::*;

module mips_hazard_scheduler #(
    parameter int REG_ADDR_W     = mips_pkg::REG_ADDR_W,
    parameter int PIPE_DEPTH     = 3,
    parameter int WB_WRITE_FIRST = 0,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_writes,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   flush,
    input  logic                   freeze,
    output logic                   pc_hold,
    output logic                   ifid_hold,
    output logic                   idex_bubble,
    output logic                   issue,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // With write-first regfile the WB slot is already readable in ID.
    localparam int CHECK = PIPE_DEPTH - WB_WRITE_FIRST;

    sb_entry_t [PIPE_DEPTH-1:0] sb;
    sb_entry_t                  push;
    logic                       shift_en;
    logic                       hazard;
    logic                       count_inc;
    logic [STALL_CNT_W-1:0]     count_q;

    mips_scoreboard_shift #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .push     (push),
        .entries  (sb)
    );

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < CHECK; i++) begin
            if (sb[i].valid && (sb[i].dest != '0) &&
                ((id_uses_rs && (sb[i].dest == id_rs)) ||
                 (id_uses_rt && (sb[i].dest == id_rt)))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & id_valid;
    end

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b1;
        issue       = 1'b0;
        shift_en    = 1'b0;
        count_inc   = 1'b0;
        push        = '0;
        if (reset) begin
            // defaults already describe the reset outputs
        end else if (freeze) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b0;
        end else if (flush) begin
            shift_en = 1'b1;
        end else if (hazard) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            shift_en  = 1'b1;
            count_inc = 1'b1;
        end else begin
            issue       = id_valid;
            idex_bubble = ~id_valid;
            shift_en    = 1'b1;
            // $0 writes are pushed invalid so they can never match
            push.valid  = id_valid & id_writes & (id_dest != '0);
            push.dest   = id_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign stall_count = count_q;

endmodule

// File: tb/tb_mips_hazard_scheduler.sv
module tb_mips_hazard_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_uses_rs, id_uses_rt, id_writes;
    logic        flush, freeze;

    logic        pc_hold0, ifid_hold0, idex_bubble0, issue0;
    logic [15:0] stall_count0;
    logic        pc_hold1, ifid_hold1, idex_bubble1, issue1;
    logic [15:0] stall_count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_hazard_scheduler dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_writes(id_writes),
        .id_dest(id_dest), .flush(flush), .freeze(freeze),
        .pc_hold(pc_hold0), .ifid_hold(ifid_hold0), .idex_bubble(idex_bubble0),
        .issue(issue0), .stall_count(stall_count0)
    );

    mips_hazard_scheduler #(.WB_WRITE_FIRST(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_writes(id_writes),
        .id_dest(id_dest), .flush(flush), .freeze(freeze),
        .pc_hold(pc_hold1), .ifid_hold(ifid_hold1), .idex_bubble(idex_bubble1),
        .issue(issue1), .stall_count(stall_count1)
    );

    // {pc_hold, ifid_hold, idex_bubble, issue}
    localparam logic [3:0] O_ISSUE  = 4'b0001;
    localparam logic [3:0] O_IDLE   = 4'b0010;
    localparam logic [3:0] O_STALL  = 4'b1110;
    localparam logic [3:0] O_FREEZE = 4'b1100;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out0(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        #1;
        obs = {pc_hold0, ifid_hold0, idex_bubble0, issue0};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed ctl=%b expected ctl=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out1(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        #1;
        obs = {pc_hold1, ifid_hold1, idex_bubble1, issue1};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed ctl=%b expected ctl=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed count=%0d expected count=%0d", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic wr, input logic [4:0] dest);
        id_valid   = v;
        id_rs      = rs;
        id_uses_rs = urs;
        id_rt      = rt;
        id_uses_rt = urt;
        id_writes  = wr;
        id_dest    = dest;
    endtask

    task automatic idle();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        flush  = 1'b0;
        freeze = 1'b0;
        idle();
        tick();

        // reset state
        chk_out0("reset_outputs", O_IDLE);
        chk_cnt("reset_count", stall_count0, 16'd0);
        tick();
        reset = 1'b0;

        // 1: addi $10 ; add $11,$12,$10 -> 3 stalls
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10);
        chk_out0("t1_addi_issue", O_ISSUE);
        tick();
        instr(1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b1, 5'd11);
        chk_out0("t1_stall1", O_STALL);
        tick();
        chk_out0("t1_stall2", O_STALL);
        chk_cnt("t1_count1", stall_count0, 16'd1);
        tick();
        chk_out0("t1_stall3", O_STALL);
        tick();
        chk_out0("t1_add_issue", O_ISSUE);
        chk_cnt("t1_count3", stall_count0, 16'd3);
        tick();
        idle();
        chk_out0("t1_idle_bubble", O_IDLE);
        do_reset();

        // 2: write-first regfile -> 2 stalls
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10);
        chk_out1("t2_addi_issue", O_ISSUE);
        tick();
        instr(1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b1, 5'd11);
        chk_out1("t2_stall1", O_STALL);
        tick();
        chk_out1("t2_stall2", O_STALL);
        tick();
        chk_out1("t2_add_issue", O_ISSUE);
        chk_cnt("t2_count2", stall_count1, 16'd2);
        tick();
        idle();
        do_reset();

        // 3: three independent instructions cover the full latency
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10);
        chk_out0("t3_addi", O_ISSUE);
        tick();
        instr(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1);
        chk_out0("t3_ind1", O_ISSUE);
        tick();
        instr(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 5'd4);
        chk_out0("t3_ind2", O_ISSUE);
        tick();
        instr(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 5'd7);
        chk_out0("t3_ind3", O_ISSUE);
        tick();
        instr(1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b1, 5'd11);
        chk_out0("t3_add_no_stall", O_ISSUE);
        chk_cnt("t3_count0", stall_count0, 16'd0);
        tick();
        idle();
        do_reset();

        // 4: $0 never hazards; lw then sw stalls on rt
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0);
        chk_out0("t4_write_r0", O_ISSUE);
        tick();
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0);
        chk_out0("t4_read_r0", O_ISSUE);
        tick();
        instr(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd16);
        chk_out0("t4_lw_issue", O_ISSUE);
        tick();
        instr(1'b1, 5'd10, 1'b1, 5'd16, 1'b1, 1'b0, 5'd0);
        chk_out0("t4_sw_stall_rt", O_STALL);
        tick();
        tick();
        tick();
        chk_out0("t4_sw_issue", O_ISSUE);
        chk_cnt("t4_count3", stall_count0, 16'd3);
        tick();
        idle();
        do_reset();

        // 5: freeze held 5 cycles during a hazard
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10);
        chk_out0("t5_addi", O_ISSUE);
        tick();
        instr(1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b1, 5'd11);
        chk_out0("t5_stall1", O_STALL);
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_out0("t5_freeze", O_FREEZE);
            tick();
        end
        chk_cnt("t5_count_frozen", stall_count0, 16'd1);
        freeze = 1'b0;
        chk_out0("t5_stall2", O_STALL);
        tick();
        chk_out0("t5_stall3", O_STALL);
        tick();
        chk_out0("t5_add_issue", O_ISSUE);
        chk_cnt("t5_count3", stall_count0, 16'd3);
        tick();
        idle();
        do_reset();

        // 6: flush coincident with hazard, then reset mid-stall
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10);
        chk_out0("t6_addi", O_ISSUE);
        tick();
        instr(1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b1, 5'd11);
        flush = 1'b1;
        chk_out0("t6_flush_bubble", O_IDLE);
        tick();
        flush = 1'b0;
        chk_cnt("t6_flush_no_count", stall_count0, 16'd0);
        chk_out0("t6_stall_after_flush", O_STALL);
        tick();
        chk_cnt("t6_count1", stall_count0, 16'd1);
        reset = 1'b1;
        chk_out0("t6_reset_outputs", O_IDLE);
        tick();
        reset = 1'b0;
        chk_out0("t6_no_hazard_after_reset", O_ISSUE);
        chk_cnt("t6_count_cleared", stall_count0, 16'd0);
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
